// File: rtl/nand_seq_pkg.sv
// Shared definitions for the NAND-sharing logic sequencer: op codes, FSM states,
// step counts and the operand-routing destinations.
package nand_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Where the output of the current NAND evaluation is written.
  typedef enum logic [1:0] {
    DST_T   = 2'b00,
    DST_U   = 2'b01,
    DST_RES = 2'b10
  } dst_e;

  localparam int unsigned STEPS_NOT = 1;
  localparam int unsigned STEPS_AND = 2;
  localparam int unsigned STEPS_OR  = 3;
  localparam int unsigned STEPS_XOR = 4;

  function automatic logic [1:0] last_step(op_e op);
    logic [1:0] idx;
    unique case (op)
      OP_NOT:  idx = 2'(STEPS_NOT - 1);
      OP_AND:  idx = 2'(STEPS_AND - 1);
      OP_OR:   idx = 2'(STEPS_OR - 1);
      OP_XOR:  idx = 2'(STEPS_XOR - 1);
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/nand_seq_nand_unit.sv
// The single shared bitwise NAND stage used by every sequencer step.
module nand_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_x0,
  input  logic [WIDTH-1:0] i_x1,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = ~(i_x0 & i_x1);

endmodule

// File: rtl/nand_seq.sv
// Multi-cycle sequencer computing NOT/AND/OR/XOR as ordered evaluations of one
// shared NAND unit, with valid/ready handshakes on both sides.
module nand_seq
  import nand_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] nand_count
);

  state_e           r_state;
  state_e           w_next_state;
  op_e              r_op;
  logic [1:0]       r_step;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_u;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_x0;
  logic [WIDTH-1:0] w_x1;
  logic [WIDTH-1:0] w_y;
  dst_e             w_dst;

  assign w_accept = in_valid & r_in_ready;
  assign w_last   = (r_step == last_step(r_op));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  if (w_last) w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs, all taken straight from registers
  always_comb begin
    out_valid  = (r_state == S_DONE);
    in_ready   = r_in_ready;
    result     = r_result;
    nand_count = r_cnt;
  end

  // Operand selection per (op, step)
  always_comb begin
    w_x0  = r_a;
    w_x1  = r_a;
    w_dst = DST_RES;
    unique case (r_op)
      OP_NOT: begin
        w_x0  = r_a;
        w_x1  = r_a;
        w_dst = DST_RES;
      end
      OP_AND: begin
        if (r_step == 2'd0) begin
          w_x0  = r_a;
          w_x1  = r_b;
          w_dst = DST_T;
        end else begin
          w_x0  = r_t;
          w_x1  = r_t;
          w_dst = DST_RES;
        end
      end
      OP_OR: begin
        case (r_step)
          2'd0:    begin w_x0 = r_a; w_x1 = r_a; w_dst = DST_T;   end
          2'd1:    begin w_x0 = r_b; w_x1 = r_b; w_dst = DST_U;   end
          default: begin w_x0 = r_t; w_x1 = r_u; w_dst = DST_RES; end
        endcase
      end
      OP_XOR: begin
        case (r_step)
          2'd0:    begin w_x0 = r_a; w_x1 = r_b; w_dst = DST_T;   end
          2'd1:    begin w_x0 = r_a; w_x1 = r_t; w_dst = DST_U;   end
          2'd2:    begin w_x0 = r_b; w_x1 = r_t; w_dst = DST_T;   end
          default: begin w_x0 = r_u; w_x1 = r_t; w_dst = DST_RES; end
        endcase
      end
      default: begin
        w_x0  = r_a;
        w_x1  = r_a;
        w_dst = DST_RES;
      end
    endcase
  end

  nand_unit #(
    .WIDTH(WIDTH)
  ) u_nand (
    .i_x0(w_x0),
    .i_x1(w_x1),
    .o_y (w_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= OP_NOT;
      r_step     <= 2'd0;
      r_a        <= '0;
      r_b        <= '0;
      r_t        <= '0;
      r_u        <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
    end else begin
      // Ready only while the FSM will sit in IDLE, so it stays registered.
      r_in_ready <= (w_next_state == S_IDLE);
      if (r_state == S_IDLE && w_accept) begin
        r_op   <= op_e'(op);
        r_a    <= a;
        r_b    <= b;
        r_step <= 2'd0;
      end
      if (r_state == S_EXEC) begin
        r_step <= r_step + 2'd1;
        if (r_cnt != {CNT_W{1'b1}}) begin
          r_cnt <= r_cnt + 1'b1;
        end
        case (w_dst)
          DST_T:   r_t      <= w_y;
          DST_U:   r_u      <= w_y;
          default: r_result <= w_y;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nand_seq.sv
// Self-checking bench for nand_seq: directed table, backpressure, mid-op reset,
// counter saturation (second instance with a 3-bit counter) and random ops.
module tb_nand_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] op = 2'b00;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;

  logic        in_ready, out_valid;
  logic [3:0]  result;
  logic [15:0] nand_count;
  logic        in_ready2, out_valid2;
  logic [3:0]  result2;
  logic [2:0]  cnt2;

  int n_checks = 0;
  int n_err = 0;
  int total = 0;

  always #5 clk = ~clk;

  nand_seq #(.WIDTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .nand_count(nand_count)
  );

  nand_seq #(.WIDTH(4), .CNT_W(3)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .result    (result2),
    .nand_count(cnt2)
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_res;
    int         lat;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_op(input logic [1:0] o, input logic [3:0] x,
                                        input logic [3:0] y);
    case (o)
      2'b00:   return ~x;
      2'b01:   return x & y;
      2'b10:   return x | y;
      default: return x ^ y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o);
    case (o)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 3;
      default: return 4;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic run_op(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] exp_res, input int exp_lat, input bit hold);
    int guard;
    int lat;
    guard = 0;
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = hold;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    total += exp_lat;
    check("latency", lat, exp_lat);
    check("result", {28'd0, result}, {28'd0, exp_res});
    check("result_sat_inst", {28'd0, result2}, {28'd0, exp_res});
    check("out_valid_sat_inst", {31'd0, out_valid2}, 32'd1);
    check("nand_count", {16'd0, nand_count}, (total > 65535) ? 65535 : total);
    check("nand_count_sat", {29'd0, cnt2}, (total > 7) ? 7 : total);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_clear", {31'd0, out_valid}, 32'd0);
    check("in_ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    logic [1:0] ro;
    logic [3:0] ra, rb;

    vecs[0] = '{op: 2'b00, a: 4'b1100, b: 4'b0000, exp_res: 4'b0011, lat: 1, exp_cnt: 1};
    vecs[1] = '{op: 2'b01, a: 4'b1100, b: 4'b1010, exp_res: 4'b1000, lat: 2, exp_cnt: 3};
    vecs[2] = '{op: 2'b10, a: 4'b1100, b: 4'b1010, exp_res: 4'b1110, lat: 3, exp_cnt: 6};
    vecs[3] = '{op: 2'b11, a: 4'b1100, b: 4'b1010, exp_res: 4'b0110, lat: 4, exp_cnt: 10};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_in_ready_sat", {31'd0, in_ready2}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {28'd0, result}, 32'd0);
    check("rst_count", {16'd0, nand_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed table
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].lat, 1'b0);
      check("table_count", {16'd0, nand_count}, vecs[i].exp_cnt);
    end

    // Backpressure: result held, no capture of a competing request
    op = 2'b11; a = 4'b1100; b = 4'b1010; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    total += 4;
    check("bp_latency", guard, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 2'b00; a = 4'hf;
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", {28'd0, result}, 32'h6);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("bp_no_capture_valid", {31'd0, out_valid}, 32'd0);
    check("bp_no_capture_ready", {31'd0, in_ready}, 32'd1);
    check("bp_count", {16'd0, nand_count}, total);

    // Reset in the middle of an XOR
    op = 2'b11; a = 4'b0101; b = 4'b0011; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total = 0;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", {28'd0, result}, 32'd0);
    check("mid_rst_count", {16'd0, nand_count}, 32'd0);
    check("mid_rst_count_sat", {29'd0, cnt2}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(2'b01, 4'b1100, 4'b1010, 4'b1000, 2, 1'b0);

    // Three XORs push the 3-bit counter into saturation
    for (int i = 0; i < 3; i++) begin
      run_op(2'b11, 4'b1100, 4'b1010, 4'b0110, 4, 1'b0);
    end
    check("sat_final", {29'd0, cnt2}, 32'd7);

    // Random operations against the model
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom);
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_op(ro, ra, rb, ref_op(ro, ra, rb), ref_lat(ro), 1'($urandom));
    end

    // Exhaustive XOR sweep with out_ready held high
    for (int i = 0; i < 256; i++) begin
      ra = 4'(i >> 4);
      rb = 4'(i);
      run_op(2'b11, ra, rb, ra ^ rb, 4, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
